// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone B3 round-robin arbiter with registered grant held for the owner's whole cyc.
// Optional watchdog (define WBARB_TIMEOUT_EN) ends stalled strobes with an err to the owner after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no owner, slave port parked at zero
// G0    | m0 owns the slave port
// G1    | m1 owns the slave port
module wb_arb2 #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [2:0]  m0_cti_i,
   input  logic [1:0]  m0_bte_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,

   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [2:0]  m1_cti_i,
   input  logic [1:0]  m1_bte_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,

   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [2:0]  s_cti_o,
   output logic [1:0]  s_bte_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,

   output logic [1:0]  gnt
);

   // State encoding doubles as the one-hot grant.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_G0   = 2'b01;
   localparam logic [1:0] ST_G1   = 2'b10;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("wb_arb2: TIMEOUT must be in 1..255");
   end

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;
   logic       sel0, sel1;
   logic       stb_raw;
   logic       s_term;
   logic       to_hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
               state_d = ST_G0;
            end else if (m1_cyc_i) begin
               state_d = ST_G1;
            end
         end
         ST_G0: begin
            if (!m0_cyc_i) begin
               state_d = m1_cyc_i ? ST_G1 : ST_IDLE;
            end
         end
         ST_G1: begin
            if (!m1_cyc_i) begin
               state_d = m0_cyc_i ? ST_G0 : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (state_d == ST_G0) begin
         last_d = 1'b0;
      end else if (state_d == ST_G1) begin
         last_d = 1'b1;
      end
   end

   // last resets to m1 so that m0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign sel0 = (state_q == ST_G0);
   assign sel1 = (state_q == ST_G1);
   assign gnt  = state_q;

   always_comb begin
      s_adr_o = 32'd0;
      s_dat_o = 32'd0;
      s_cyc_o = 1'b0;
      stb_raw = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = 4'd0;
      s_cti_o = 3'd0;
      s_bte_o = 2'd0;
      if (sel0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_cyc_o = m0_cyc_i;
         stb_raw = m0_stb_i;
         s_we_o  = m0_we_i;
         s_sel_o = m0_sel_i;
         s_cti_o = m0_cti_i;
         s_bte_o = m0_bte_i;
      end else if (sel1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_cyc_o = m1_cyc_i;
         stb_raw = m1_stb_i;
         s_we_o  = m1_we_i;
         s_sel_o = m1_sel_i;
         s_cti_o = m1_cti_i;
         s_bte_o = m1_bte_i;
      end
   end

   assign s_term  = s_ack_i | s_err_i | s_rty_i;
   assign s_stb_o = stb_raw & ~to_hit;

`ifdef WBARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   logic [7:0] wdog_q, wdog_d;

   assign to_hit = (wdog_q == TO_LIMIT);

   always_comb begin
      if (to_hit || !stb_raw || s_term) begin
         wdog_d = 8'd0;
      end else begin
         wdog_d = wdog_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= 8'd0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   assign m0_ack_o = sel0 & s_ack_i;
   assign m0_err_o = sel0 & (s_err_i | to_hit);
   assign m0_rty_o = sel0 & s_rty_i;
   assign m1_ack_o = sel1 & s_ack_i;
   assign m1_err_o = sel1 & (s_err_i | to_hit);
   assign m1_rty_o = sel1 & s_rty_i;

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master Wishbone B3 arbiter that shares a single Wishbone slave port, the `ahb2wb` bridge in front of `mctrl` and its SDRAM, between two independent requesters, such as a CPU data port and a DMA engine. It performs round-robin arbitration with a registered grant. Grant is held for the whole `cyc` of the owner, so classic cycles and incrementing bursts (`WBCTI_INCRBURST` … `WBCTI_ENDBURST`) are never split. An optional watchdog terminates stalled cycles with an error.

## Interface
Parameters:
- `TIMEOUT`, default 255. Watchdog limit in cycles; only used with `WBARB_TIMEOUT_EN`. Legal range 1-255.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_adr_i`, `m1_adr_i`  in  32  master address.
- `m0_dat_i`, `m1_dat_i`  in  32  master write data.
- `m0_cyc_i`, `m1_cyc_i`  in  1  cycle request; also the arbitration request.
- `m0_stb_i`, `m1_stb_i`  in  1  strobe.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_sel_i`, `m1_sel_i`  in  4  byte selects.
- `m0_cti_i`, `m1_cti_i`  in  3  cycle type.
- `m0_bte_i`, `m1_bte_i`  in  2  burst type.
- `m0_dat_o`, `m1_dat_o`  out  32  read data; `s_dat_i` fanned out to both.
- `m0_ack_o`/`m0_err_o`/`m0_rty_o` and `m1_ack_o`/`m1_err_o`/`m1_rty_o`  out  1 each  terminations; gated to the granted master only.
- `s_adr_o`, `s_dat_o`, `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_cti_o`, `s_bte_o`  out  32/32/1/1/1/4/3/2  slave-side copy of the granted master's signals.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each  slave terminations.
- `gnt`  out  2  one-hot grant: bit0 = m0, bit1 = m1, 00 = idle.

## Operation
- FSM states are IDLE, G0 and G1, with `gnt` = 00, 01 and 10 respectively. A 1-bit `last` register records the most recently granted master.
- **IDLE:**
  - Only m0 `cyc` high → go to G0. Only m1 `cyc` high → go to G1.
  - Both high → grant the master ≠ `last`.
  - Neither high → stay in IDLE.
- **G0 / G1:**
  - Stay while the owner's `cyc_i` = 1; any `cti` value is accepted, and burst lock is implicit.
  - Owner `cyc_i` = 0 at an edge: if the other master's `cyc_i` = 1, hand over directly to it (G0→G1 or G1→G0); otherwise go to IDLE.
  - `last` updates on every entry to G0 or G1.
- **Slave side mux:**
  - In G0/G1, all `s_*_o` outputs equal the owner's inputs.
  - In IDLE, `s_cyc_o`, `s_stb_o`, `s_we_o` and `s_sel_o` are 0, and the address/data/`cti`/`bte` outputs are 0.
- **Master side:**
  - Owner: `ack`/`err`/`rty` = slave inputs.
  - Non-owner: terminations are 0 and it waits with `cyc` held.
- Reset: state IDLE, `last` = 1 (so m0 wins the first tie), `gnt` = 00, all outputs 0, watchdog counter 0.
- Reset asserted mid-cycle: the grant drops immediately and `s_cyc_o` goes to 0 asynchronously. No termination is issued to the interrupted master.

## Timing
- Grant latency: a `cyc` rising before edge N gives `gnt` and `s_cyc_o` high in the cycle after edge N. That is one cycle of added latency when the bus is idle, with no added latency within a cycle.
- Termination path is combinational: `s_ack_i` → `mN_ack_o` with zero cycles of delay. Throughput of a held burst is unaffected (one ack per clk possible).
- Hand-over: the owner's `cyc` low in cycle k gives the other master `s_cyc_o` in cycle k+1. There is at least one cycle with `s_cyc_o` = 0 between owners, because the owner's own low-`cyc` cycle is that gap.
- Simultaneous release by the owner and new requests from both masters: the non-owner wins, by round-robin.

## Configuration
- `WBARB_TIMEOUT_EN` defined:
  - An 8-bit counter increments each cycle with `s_stb_o` = 1 and no `s_ack_i`/`s_err_i`/`s_rty_i`. It clears on any termination or when `s_stb_o` = 0.
  - When the count = `TIMEOUT`, the owner's `err_o` = 1 for exactly one cycle, `s_stb_o` is forced to 0 that cycle, and the counter clears.
- `WBARB_TIMEOUT_EN` undefined: no counter is built, `err` comes from the slave only, and `TIMEOUT` is ignored.

## Test plan
- m0 alone writes 0x20000000 = 0 (classic): `gnt` = 01 one cycle after `cyc` rises, a single `m0_ack_o`, `m1_ack_o` stays 0, and `gnt` = 00 the cycle after `cyc` falls.
- m0 and m1 request on the same edge straight out of reset: m0 is granted first. At m0's release, m1 is granted directly (01→10 with no IDLE state). The next tie goes to m0.
- m1 performs a 5-beat INCRBURST write to 0x20000000-0x20000010 (data 0-4, last beat ENDBURST) while m0 requests throughout: no grant change until m1's `cyc` drops. A read-back burst by m0 returns 0,1,2,3,4.
- Reset asserted during m0's burst: `s_cyc_o` = 0 and `gnt` = 00 immediately. After reset, m0's re-issued read of 0x20000004 returns 1.
- With `WBARB_TIMEOUT_EN` and `TIMEOUT` = 16, the slave never acks: `m0_err_o` pulses once, 16 cycles after `s_stb_o` rises, and `m1_err_o` stays 0.
- Without the macro, the same stalled slave leaves `m0_err_o` at 0 indefinitely and `gnt` stays 01.
